// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and bubble insertion.
// Define PIPE_STAGE_REG_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_reg #(
  parameter int                  INSTR_W   = 14,
  parameter int                  CTRL_W    = 18,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic [CTRL_W-1:0]  ctrl_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [1:0]         occupancy
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [CTRL_W-1:0]  ctrl;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam entry_t BUBBLE = '{instr: NOP_INSTR, ctrl: '0};

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept, drain;

  // Handshake flags come from registered state only, so in_ready never depends on out_ready.
  assign in_ready        = (state_q != FULL);
  assign out_valid       = (state_q != EMPTY);
  assign occupancy       = state_q;
  assign instruction_out = main_q.instr;
  assign ctrl_out        = main_q.ctrl;
  assign in_entry        = '{instr: instruction_in, ctrl: ctrl_in};
  assign accept          = in_valid && in_ready;
  assign drain           = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          state_d = ONE;
          main_d  = in_entry;
        end
        ONE: begin
          if (accept && !drain) begin
            state_d = FULL;
            skid_d  = in_entry;
          end else if (accept && drain) begin
            main_d  = in_entry;
          end else if (drain) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end
        end
        FULL: if (drain) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Flush leaves the counter alone; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: per-cycle stimulus table plus a scoreboard-fed output monitor.
module tb_pipe_stage_reg;

  localparam int INSTR_W = 14;
  localparam int CTRL_W  = 18;

  logic               clk = 1'b0;
  logic               rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [INSTR_W-1:0] instruction_in, instruction_out;
  logic [CTRL_W-1:0]  ctrl_in, ctrl_out;
  logic [1:0]         occupancy;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
  logic [15:0]        stall_cnt;
`endif

  pipe_stage_reg #(.INSTR_W(INSTR_W), .CTRL_W(CTRL_W), .NOP_INSTR('0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .ctrl_in(ctrl_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .instruction_out(instruction_out), .ctrl_out(ctrl_out),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [CTRL_W-1:0]  ctrl;
  } exp_t;

  typedef struct {
    logic               vld;
    logic [INSTR_W-1:0] instr;
    logic [CTRL_W-1:0]  ctrl;
    logic               ordy;
    logic               fl;
    logic               rstn;
    logic               keep;    // entry is accepted this cycle and must later emerge
    logic [1:0]         occ;     // expected occupancy seen during this cycle
  } row_t;

  exp_t sb[$];
  row_t rows[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [INSTR_W-1:0] IA = 14'h0123, IB = 14'h0456, IC = 14'h0789,
                                 ID = 14'h0ABC, IE = 14'h1DEF;
  localparam logic [CTRL_W-1:0]  CA = 18'h0A5A5, CB = 18'h15A5A, CC = 18'h3FFFF,
                                 CD = 18'h00001, CE = 18'h20000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic row_t mk(input logic v, input logic [INSTR_W-1:0] i, input logic [CTRL_W-1:0] c,
                              input logic o, input logic f, input logic r, input logic k,
                              input logic [1:0] occ);
    row_t x;
    x.vld = v; x.instr = i; x.ctrl = c; x.ordy = o; x.fl = f; x.rstn = r; x.keep = k; x.occ = occ;
    return x;
  endfunction

  // Output monitor: every retired transfer must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got instr %0h ctrl %0h with nothing expected", instruction_out, ctrl_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_instr", 32'(instruction_out), 32'(e.instr));
        chk("out_ctrl", 32'(ctrl_out), 32'(e.ctrl));
      end
    end
  end

  task automatic apply(input row_t r);
    rst_n          = r.rstn;
    flush          = r.fl;
    in_valid       = r.vld;
    instruction_in = r.instr;
    ctrl_in        = r.ctrl;
    out_ready      = r.ordy;
    if (r.keep) sb.push_back('{instr: r.instr, ctrl: r.ctrl});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction_in = '0; ctrl_in = '0;

    //            vld  instr ctrl ordy fl  rstn keep occ
    rows.push_back(mk(0, '0,  '0,  1,  0,  1,  0,  0)); // reset state
    rows.push_back(mk(1, IA,  CA,  1,  0,  1,  1,  0)); // stream A,B,C
    rows.push_back(mk(1, IB,  CB,  1,  0,  1,  1,  1));
    rows.push_back(mk(1, IC,  CC,  1,  0,  1,  1,  1));
    rows.push_back(mk(0, '0,  '0,  1,  0,  1,  0,  1));
    rows.push_back(mk(0, '0,  '0,  0,  0,  1,  0,  0));
    rows.push_back(mk(1, IA,  CA,  0,  0,  1,  1,  0)); // back-pressure fills skid
    rows.push_back(mk(1, IB,  CB,  0,  0,  1,  1,  1));
    rows.push_back(mk(1, IC,  CC,  0,  0,  1,  0,  2));
    rows.push_back(mk(1, IC,  CC,  0,  0,  1,  0,  2));
    rows.push_back(mk(1, IC,  CC,  1,  0,  1,  0,  2)); // A drains, C still blocked
    rows.push_back(mk(1, IC,  CC,  1,  0,  1,  1,  1)); // B drains, C accepted
    rows.push_back(mk(0, '0,  '0,  1,  0,  1,  0,  1));
    rows.push_back(mk(0, '0,  '0,  0,  0,  1,  0,  0));
    rows.push_back(mk(1, IA,  CA,  0,  0,  1,  0,  0)); // fill then flush
    rows.push_back(mk(1, IB,  CB,  0,  0,  1,  0,  1));
    rows.push_back(mk(1, IC,  CC,  0,  1,  1,  0,  2));
    rows.push_back(mk(0, '0,  '0,  1,  0,  1,  0,  0));
    rows.push_back(mk(1, ID,  CD,  1,  0,  1,  0,  0)); // flush during accept+drain
    rows.push_back(mk(1, IE,  CE,  1,  1,  1,  0,  1));
    rows.push_back(mk(0, '0,  '0,  1,  0,  1,  0,  0));
    rows.push_back(mk(1, IA,  CA,  0,  0,  1,  0,  0)); // reset while FULL
    rows.push_back(mk(1, IB,  CB,  0,  0,  1,  0,  1));
    rows.push_back(mk(0, '0,  '0,  1,  0,  0,  0,  2));
    rows.push_back(mk(0, '0,  '0,  1,  0,  1,  0,  0));
    rows.push_back(mk(0, '0,  '0,  1,  0,  1,  0,  0));

    repeat (2) @(posedge clk);
    foreach (rows[k]) begin
      #1 apply(rows[k]);
      @(negedge clk);
      chk($sformatf("occupancy[%0d]", k), 32'(occupancy), 32'(rows[k].occ));
      chk($sformatf("in_ready[%0d]", k), 32'(in_ready), 32'(rows[k].occ != 2'd2));
      chk($sformatf("out_valid[%0d]", k), 32'(out_valid), 32'(rows[k].occ != 2'd0));
      if (rows[k].occ == 2'd0) begin
        chk($sformatf("bubble_instr[%0d]", k), 32'(instruction_out), 32'd0);
        chk($sformatf("bubble_ctrl[%0d]", k), 32'(ctrl_out), 32'd0);
      end
      @(posedge clk);
    end

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    #1 apply(mk(0, '0, '0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 apply(mk(1, IA, CA, 0, 0, 1, 1, 0));
    @(posedge clk);
    #1 apply(mk(0, '0, '0, 0, 0, 1, 0, 0));
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("stall_cnt_5", 32'(stall_cnt), 32'd5);
    repeat (65535) @(posedge clk);
    @(negedge clk);
    chk("stall_cnt_sat", 32'(stall_cnt), 32'hFFFF);
    @(posedge clk);
    #1 apply(mk(1, IB, CB, 0, 1, 1, 0, 0));
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("stall_cnt_flush_kept", 32'(stall_cnt), 32'hFFFF);
    sb.delete();
    #1 apply(mk(0, '0, '0, 1, 0, 1, 0, 0));
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
